// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential divider controller and its step cell.
//   DIV_WIDTH    : default operand width
//   DIV_CNT_W    : width of the iteration counter
//   DIV_DBZ_QUOT : quotient reported when the divisor is zero (all ones)
//   div_state_e  : controller states
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  localparam logic [DIV_WIDTH-1:0] DIV_DBZ_QUOT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_ITER = 2'd2,
    ST_FIX  = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One restoring shift-subtract iteration on magnitudes.
//   i_a : partial remainder A (always < M on entry)
//   i_q : partial quotient / remaining dividend bits Q
//   i_m : divisor magnitude M
//   o_a : next A
//   o_q : next Q (shifted left, new quotient bit in bit 0)
// -----------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_q
);

  // The shifted remainder can reach 2*M-1, which needs WIDTH+1 bits when M
  // uses the full unsigned range; one more bit holds the borrow.
  logic [WIDTH:0]   w_a_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_borrow;

  assign w_a_sh   = {i_a, i_q[WIDTH-1]};
  assign w_diff   = {1'b0, w_a_sh} - {2'b00, i_m};
  assign w_borrow = w_diff[WIDTH+1];

  always_comb begin
    o_a = WIDTH'(w_a_sh);
    o_q = {i_q[WIDTH-2:0], 1'b0};
    if (!w_borrow) begin
      // Difference is below M, so it always fits in WIDTH bits.
      o_a = WIDTH'(w_diff);
      o_q = {i_q[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
// Sequential restoring divider: one quotient bit per clock behind a
// start/done handshake, with signed support via magnitude conversion and
// sign fix-up, and divide-by-zero detection.
//
// Ports
//   i_clk          : rising-edge clock
//   i_rst_n        : asynchronous active-low reset
//   i_start        : request, sampled only in IDLE
//   i_signed_op    : 1 = two's-complement, 0 = unsigned (captured with start)
//   i_dividend     : dividend (captured with start)
//   i_divisor      : divisor (captured with start)
//   o_busy         : high from the cycle after start is accepted until done
//   o_done         : one-cycle pulse when o_z is valid
//   o_div_by_zero  : sticky for the last operation, cleared on accepted start
//   o_z            : {quotient, remainder}, held until the next done
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; result and flag held
// PREP  | zero check, magnitudes and result signs derived
// ITER  | WIDTH shift-subtract steps, one per clock
// FIX   | sign fix-up, load o_z, pulse o_done
// -----------------------------------------------------------------------------
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_signed_op,
  input  logic [WIDTH-1:0]   i_dividend,
  input  logic [WIDTH-1:0]   i_divisor,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_div_by_zero,
  output logic [2*WIDTH-1:0] o_z
);

  localparam int CW = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_e       r_state;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic             r_signed;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_cnt;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_dbz;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  // Negation of the most negative value wraps to itself, which is exactly
  // the unsigned magnitude 2^(WIDTH-1), so no special case is needed.
  assign w_dvd_neg = r_signed & r_dividend[WIDTH-1];
  assign w_dvs_neg = r_signed & r_divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -r_dividend : r_dividend;
  assign w_dvs_mag = w_dvs_neg ? -r_divisor  : r_divisor;

  // Remainder takes the dividend's sign (truncating division); the
  // -2^(W-1) / -1 overflow falls out as a wrapped quotient.
  assign w_quot = r_qneg ? -r_q : r_q;
  assign w_rem  = r_rneg ? -r_a : r_a;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_a (r_a),
    .i_q (r_q),
    .i_m (r_m),
    .o_a (w_a_nxt),
    .o_q (w_q_nxt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_dividend    <= '0;
      r_divisor     <= '0;
      r_signed      <= 1'b0;
      r_a           <= '0;
      r_q           <= '0;
      r_m           <= '0;
      r_cnt         <= '0;
      r_qneg        <= 1'b0;
      r_rneg        <= 1'b0;
      r_dbz         <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_div_by_zero <= 1'b0;
      o_z           <= '0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_dividend    <= i_dividend;
            r_divisor     <= i_divisor;
            r_signed      <= i_signed_op;
            o_div_by_zero <= 1'b0;
            o_busy        <= 1'b1;
            r_state       <= ST_PREP;
          end
        end

        ST_PREP: begin
          r_a   <= '0;
          r_cnt <= '0;
          if (r_divisor == '0) begin
            r_dbz   <= 1'b1;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_state <= ST_FIX;
          end else begin
            r_dbz   <= 1'b0;
            r_q     <= w_dvd_mag;
            r_m     <= w_dvs_mag;
            r_qneg  <= w_dvd_neg ^ w_dvs_neg;
            r_rneg  <= w_dvd_neg;
            r_state <= ST_ITER;
          end
        end

        ST_ITER: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_STEP) begin
            r_state <= ST_FIX;
          end
        end

        ST_FIX: begin
          if (r_dbz) begin
            o_z           <= {{WIDTH{DIV_DBZ_QUOT[0]}}, r_dividend};
            o_div_by_zero <= 1'b1;
          end else begin
            o_z <= {w_quot, w_rem};
          end
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [63:0] z;

  div_seq_ctrl #(.WIDTH(32)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_signed_op   (signed_op),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_busy        (busy),
    .o_done        (done),
    .o_div_by_zero (dbz),
    .o_z           (z)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] z;
    logic        dbz;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division on 64-bit values; SystemVerilog
  // division truncates toward zero and % follows the dividend's sign.
  function automatic exp_t ref_div(input logic sgn, input logic [31:0] a,
                                   input logic [31:0] b, input int start_cyc);
    exp_t        e;
    longint      sa, sb, qq, rr;
    logic [63:0] qv, rv;
    if (b == 32'd0) begin
      e.z   = {32'hFFFF_FFFF, a};
      e.dbz = 1'b1;
      e.lat = 2;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      qq = sa / sb;
      rr = sa % sb;
      qv = qq;
      rv = rr;
      e.z   = {qv[31:0], rv[31:0]};
      e.dbz = 1'b0;
      e.lat = 34;
    end
    e.start_cyc = start_cyc;
    return e;
  endfunction

  // Drive one request for a single edge; operands are scrambled afterwards
  // so a result built from live inputs instead of captured ones shows up.
  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    signed_op = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    sb_q.push_back(ref_div(sgn, a, b, cyc + 1));
    @(negedge clk);
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    signed_op = ~sgn;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (sb_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: %0d operation(s) still pending after %0d cycles", sb_q.size(), max_cyc);
      sb_q.delete();
    end
  endtask

  // Monitor: compares every done pulse against the oldest expected entry and
  // checks busy while an accepted operation is in flight.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: z=0x%0h with nothing pending", z);
          end else begin
            e = sb_q.pop_front();
            check("z", z, e.z);
            check("div_by_zero", 64'(dbz), 64'(e.dbz));
            check("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
            check("busy_at_done", 64'(busy), 64'd0);
          end
        end else if (sb_q.size() != 0 && cyc >= sb_q[0].start_cyc) begin
          check("busy_in_flight", 64'(busy), 64'd1);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        sgn;
    logic [31:0] a, b;
    int          sel;
    bit          seen;

    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dbz", 64'(dbz), 64'd0);
    check("reset_z", z, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(1'b0, 32'd100, 32'd7);            wait_idle(60);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2);      wait_idle(60);
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE);      wait_idle(60);
    do_op(1'b0, 32'h1234_5678, 32'd0);      wait_idle(10);
    repeat (3) @(negedge clk);
    check("dbz_sticky", 64'(dbz), 64'd1);
    do_op(1'b0, 32'd20, 32'd3);
    check("dbz_cleared_on_start", 64'(dbz), 64'd0);
    wait_idle(60);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle(60);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1);         wait_idle(60);

    // Start while busy must be ignored.
    do_op(1'b0, 32'd50, 32'd5);
    repeat (9) @(negedge clk);
    signed_op = 1'b0;
    dividend  = 32'd9;
    divisor   = 32'd3;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(60);

    // Start asserted during the done cycle is accepted.
    do_op(1'b0, 32'd1000, 32'd10);
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: done not seen for back-to-back test");
    end
    do_op(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_idle(80);

    // Reset in the middle of an operation.
    do_op(1'b0, 32'd12345, 32'd67);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_z", z, 64'd0);
    sb_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    do_op(1'b0, 32'd12345, 32'd67);
    wait_idle(60);

    for (int i = 0; i < 40; i++) begin
      sgn = 1'(($urandom_range(0, 1)));
      a   = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3, 4, 5: b = $urandom_range(1, 255);
        default: b = $urandom;
      endcase
      do_op(sgn, a, b);
      wait_idle(60);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
